// File: rtl/comparator_4bit_pkg.sv
// Shared opcode encoding and default operand width for the comparator slice.
package comparator_4bit_pkg;

    localparam int CMP_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        CMP_LT = 2'b00,
        CMP_EQ = 2'b01,
        CMP_GT = 2'b10,
        CMP_NE = 2'b11
    } cmp_op_e;

endpackage

// File: rtl/cmp_bit_cell.sv
// One bit of an MSB-first magnitude cascade: once an upstream bit has decided
// the order, lower bits can no longer change it.
module cmp_bit_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic gt_in,
    input  logic lt_in,
    output logic gt_out,
    output logic lt_out
);

    logic undecided;

    always_comb begin
        undecided = ~(gt_in | lt_in);
        gt_out    = gt_in | (undecided & a_i & ~b_i);
        lt_out    = lt_in | (undecided & ~a_i & b_i);
    end

endmodule

// File: rtl/comparator_4bit.sv
// Registered unsigned comparator: lt/eq/gt flags plus an opcode-selected result,
// all available one cycle after the operands are sampled.
module comparator_4bit
    import comparator_4bit_pkg::*;
#(
    parameter int DATA_WIDTH = CMP_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_A,
    input  logic [DATA_WIDTH-1:0] data_B,
    input  logic [1:0]            select,
    output logic                  result,
    output logic                  lt,
    output logic                  eq,
    output logic                  gt
);

    // Chain index DATA_WIDTH is the "nothing decided yet" seed above the MSB.
    logic [DATA_WIDTH:0] gt_chain;
    logic [DATA_WIDTH:0] lt_chain;

    assign gt_chain[DATA_WIDTH] = 1'b0;
    assign lt_chain[DATA_WIDTH] = 1'b0;

    for (genvar i = DATA_WIDTH - 1; i >= 0; i--) begin : g_cell
        cmp_bit_cell u_cell (
            .a_i    (data_A[i]),
            .b_i    (data_B[i]),
            .gt_in  (gt_chain[i+1]),
            .lt_in  (lt_chain[i+1]),
            .gt_out (gt_chain[i]),
            .lt_out (lt_chain[i])
        );
    end

    logic result_d, lt_d, eq_d, gt_d;
    logic result_q, lt_q, eq_q, gt_q;

    always_comb begin
        gt_d = gt_chain[0];
        lt_d = lt_chain[0];
        eq_d = ~(gt_chain[0] | lt_chain[0]);
        case (cmp_op_e'(select))
            CMP_LT:  result_d = lt_d;
            CMP_EQ:  result_d = eq_d;
            CMP_GT:  result_d = gt_d;
            CMP_NE:  result_d = ~eq_d;
            default: result_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b1;
            gt_q     <= 1'b0;
        end else begin
            result_q <= result_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
        end
    end

    assign result = result_q;
    assign lt     = lt_q;
    assign eq     = eq_q;
    assign gt     = gt_q;

endmodule

// File: tb/tb_comparator_4bit.sv
// Scoreboard bench for comparator_4bit: expectations queued at drive time,
// compared one cycle later against an integer model.
module tb_comparator_4bit;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_A = '0;
    logic [DW-1:0] data_B = '0;
    logic [1:0]    select = 2'b00;
    logic          result, lt, eq, gt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic  res;
        logic  lt;
        logic  eq;
        logic  gt;
        string tag;
    } exp_t;

    exp_t sb[$];

    comparator_4bit #(.DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .data_A (data_A),
        .data_B (data_B),
        .select (select),
        .result (result),
        .lt     (lt),
        .eq     (eq),
        .gt     (gt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int sel, input string tag);
        exp_t e;
        e.lt = (a < b);
        e.eq = (a == b);
        e.gt = (a > b);
        case (sel)
            0:       e.res = (a < b);
            1:       e.res = (a == b);
            2:       e.res = (a > b);
            default: e.res = (a != b);
        endcase
        e.tag = tag;
        return e;
    endfunction

    // Called at a falling edge: outputs reflect the most recent rising edge.
    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_result"}, {31'b0, result}, {31'b0, e.res});
        check({e.tag, "_lt"}, {31'b0, lt}, {31'b0, e.lt});
        check({e.tag, "_eq"}, {31'b0, eq}, {31'b0, e.eq});
        check({e.tag, "_gt"}, {31'b0, gt}, {31'b0, e.gt});
        check({e.tag, "_onehot"}, 32'(int'(lt) + int'(eq) + int'(gt)), 32'd1);
    endtask

    task automatic drive(input int a, input int b, input int sel, input string tag);
        @(negedge clk);
        if (sb.size() != 0) pop_check();
        data_A = DW'(a);
        data_B = DW'(b);
        select = 2'(sel);
        sb.push_back(model(a, b, sel, tag));
    endtask

    task automatic flush();
        @(negedge clk);
        if (sb.size() != 0) pop_check();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_result"}, {31'b0, result}, 32'd0);
        check({tag, "_lt"}, {31'b0, lt}, 32'd0);
        check({tag, "_eq"}, {31'b0, eq}, 32'd1);
        check({tag, "_gt"}, {31'b0, gt}, 32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2 check_reset_vals("rst_init");
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst_held");
        rst = 1'b0;

        drive(4'b0101, 4'b1010, 0, "s30");
        drive(4'b1111, 4'b1111, 1, "s31");
        drive(4'b1010, 4'b0101, 2, "s32a");
        drive(4'b1010, 4'b0101, 3, "s32b");
        drive(4'b1010, 4'b0101, 0, "s32c");
        drive(4'b1000, 4'b0111, 2, "s33a");
        drive(4'b0000, 4'b0000, 3, "s33b");
        drive(4'b1111, 4'b0000, 2, "b_ones_zeros");
        drive(4'b0000, 4'b1111, 0, "b_zeros_ones");
        drive(4'b0000, 4'b0000, 1, "b_zeros_zeros");
        drive(4'b0001, 4'b0000, 2, "b_lsb");
        flush();

        // Mid-cycle asynchronous reset while result is 1.
        drive(4'b0011, 4'b1100, 0, "pre_rst");
        flush();
        check({31'b0, result} == 32'd1 ? "pre_rst_hi" : "pre_rst_hi", {31'b0, result}, 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_async");
        @(posedge clk);
        #1 check_reset_vals("rst_over_edge");
        @(negedge clk);
        rst = 1'b0;
        drive(4'b1100, 4'b0011, 2, "post_rst");
        flush();

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int s = 0; s < 4; s++)
                    drive(a, b, s, "exh");
        flush();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
